// File: rtl/round_iteration_sequencer_if.sv
// Bundle of block-in, round-core and block-out handshakes for round_iteration_sequencer.
// slave is the sequencer side; master is the driver/environment side.
interface round_iteration_sequencer_if #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned ROUND_W   = 4,
  parameter int unsigned ADDR_W    = 4
);
  localparam int unsigned B = WORD_W * NUM_WORDS;

  logic               iClear;
  logic               iEndec;
  logic [ROUND_W-1:0] iRound;
  logic               iData_valid;
  logic               oIn_ready;
  logic [B-1:0]       iData;
  logic               oCore_valid;
  logic [B-1:0]       oCore_data;
  logic [ADDR_W-1:0]  oKey_addr;
  logic               oLast_pass;
  logic               iCore_valid;
  logic [B-1:0]       iCore_data;
  logic               oData_valid;
  logic [B-1:0]       oData;
  logic               iOut_ready;
  logic               oBusy;
  logic [ROUND_W-1:0] oRound_idx;
  logic               oOverrun;

  modport slave (
    input  iClear, iEndec, iRound, iData_valid, iData, iCore_valid, iCore_data, iOut_ready,
    output oIn_ready, oCore_valid, oCore_data, oKey_addr, oLast_pass, oData_valid, oData,
           oBusy, oRound_idx, oOverrun
  );

  modport master (
    output iClear, iEndec, iRound, iData_valid, iData, iCore_valid, iCore_data, iOut_ready,
    input  oIn_ready, oCore_valid, oCore_data, oKey_addr, oLast_pass, oData_valid, oData,
           oBusy, oRound_idx, oOverrun
  );
endinterface

// File: rtl/round_iteration_sequencer.sv
// Drives an external single-round core for N passes per block, feeding results back,
// with per-pass key addressing, ready/valid backpressure, abort and sticky overrun.
module round_iteration_sequencer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned ROUND_W   = 4,
  parameter int unsigned ADDR_W    = 4
) (
  input logic                    iClk,
  input logic                    iRst_n,
  round_iteration_sequencer_if.slave bus
);
  localparam int unsigned B = WORD_W * NUM_WORDS;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} stateE;

  stateE              stateQ, stateD;
  logic [ROUND_W-1:0] roundQ, roundD;
  logic [ROUND_W-1:0] nQ, nD;
  logic               endecQ, endecD;
  logic [B-1:0]       dataQ, dataD;
  logic [ADDR_W-1:0]  keyQ, keyD;
  logic               overrunQ, overrunD;
  logic [ROUND_W-1:0] lastIdx;
  logic [ROUND_W-1:0] roundNext;

  assign lastIdx   = nQ - 1'b1;
  assign roundNext = roundQ + 1'b1;

  always_comb begin
    stateD   = stateQ;
    roundD   = roundQ;
    nD       = nQ;
    endecD   = endecQ;
    dataD    = dataQ;
    keyD     = keyQ;
    overrunD = overrunQ;

    // A core response is only meaningful while waiting for one.
    if (bus.iCore_valid && (stateQ != StWait)) overrunD = 1'b1;

    if (bus.iClear) begin
      stateD   = StIdle;
      roundD   = '0;
      dataD    = '0;
      keyD     = '0;
      overrunD = 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (bus.iData_valid) begin
            dataD  = bus.iData;
            nD     = bus.iRound;
            endecD = bus.iEndec;
            roundD = '0;
            keyD   = '0;
            if (bus.iRound != '0) begin
              stateD = StIssue;
              if (bus.iEndec) keyD = ADDR_W'(ROUND_W'(bus.iRound - 1'b1));
            end else begin
              stateD = StDone;
            end
          end
        end
        StIssue: stateD = StWait;
        StWait: begin
          if (bus.iCore_valid) begin
            dataD = bus.iCore_data;
            if (roundQ == lastIdx) begin
              stateD = StDone;
            end else begin
              roundD = roundNext;
              stateD = StIssue;
              keyD   = endecQ ? ADDR_W'(ROUND_W'(lastIdx - roundNext)) : ADDR_W'(roundNext);
            end
          end
        end
        StDone: if (bus.iOut_ready) stateD = StIdle;
        default: stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ   <= StIdle;
      roundQ   <= '0;
      nQ       <= '0;
      endecQ   <= 1'b0;
      dataQ    <= '0;
      keyQ     <= '0;
      overrunQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      roundQ   <= roundD;
      nQ       <= nD;
      endecQ   <= endecD;
      dataQ    <= dataD;
      keyQ     <= keyD;
      overrunQ <= overrunD;
    end
  end

  assign bus.oIn_ready   = (stateQ == StIdle);
  assign bus.oBusy       = (stateQ != StIdle);
  assign bus.oCore_valid = (stateQ == StIssue);
  assign bus.oLast_pass  = (stateQ == StIssue) && (roundQ == lastIdx);
  assign bus.oCore_data  = dataQ;
  assign bus.oKey_addr   = keyQ;
  assign bus.oData_valid = (stateQ == StDone);
  assign bus.oData       = dataQ;
  assign bus.oRound_idx  = roundQ;
  assign bus.oOverrun    = overrunQ;
endmodule

// File: tb/tb_round_iteration_sequencer.sv
// Directed bench for round_iteration_sequencer with a latency-programmable XOR-key core model.
module tb_round_iteration_sequencer;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned ROUND_W   = 4;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned B         = WORD_W * NUM_WORDS;

  logic iClk;
  logic iRst_n;
  int   checks = 0;
  int   errors = 0;

  round_iteration_sequencer_if #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .ROUND_W(ROUND_W), .ADDR_W(ADDR_W)
  ) bus ();

  round_iteration_sequencer #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .ROUND_W(ROUND_W), .ADDR_W(ADDR_W)
  ) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (bus)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Core model: answers L cycles after each launch with data XOR key address per word.
  logic              coreEn = 1'b1;
  int                coreLat = 1;
  int                countdown = 0;
  logic [B-1:0]      pending = '0;
  logic              modelValid = 1'b0;
  logic [B-1:0]      modelData = '0;
  logic              manualValid = 1'b0;
  logic [B-1:0]      manualData = '0;
  int                launchCount = 0;
  logic [ADDR_W-1:0] logAddr [256];
  logic              logLast [256];
  logic [ROUND_W-1:0] logIdx [256];

  assign bus.iCore_valid = modelValid | manualValid;
  assign bus.iCore_data  = modelValid ? modelData : manualData;

  initial begin
    forever begin
      @(posedge iClk);
      #1;
      modelValid = 1'b0;
      if (countdown > 0) begin
        countdown = countdown - 1;
        if (countdown == 0 && coreEn) begin
          modelValid = 1'b1;
          modelData  = pending;
        end
      end
      if (bus.oCore_valid) begin
        countdown = coreLat;
        pending   = bus.oCore_data ^ {NUM_WORDS{WORD_W'(bus.oKey_addr)}};
        if (launchCount < 256) begin
          logAddr[launchCount] = bus.oKey_addr;
          logLast[launchCount] = bus.oLast_pass;
          logIdx[launchCount]  = bus.oRound_idx;
        end
        launchCount = launchCount + 1;
      end
    end
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Accepts one block in cycle 0 and returns the cycle oData_valid first rises.
  task automatic run_txn(input logic endec, input logic [ROUND_W-1:0] n,
                         input logic [B-1:0] data, input int lat,
                         output int doneCyc, output int base);
    int w;
    coreLat = lat;
    coreEn  = 1'b1;
    w = 0;
    while (!bus.oIn_ready && w < 100) begin
      step();
      w++;
    end
    if (!bus.oIn_ready) begin
      checks++; errors++;
      $display("FAIL accept_wait oIn_ready got 0 want 1");
    end
    base = launchCount;
    bus.iData = data; bus.iRound = n; bus.iEndec = endec; bus.iData_valid = 1'b1;
    step();
    bus.iData_valid = 1'b0;
    bus.iRound = ~n; bus.iEndec = ~endec; bus.iData = '1;
    doneCyc = 1;
    while (!bus.oData_valid && doneCyc < 1000) begin
      step();
      doneCyc++;
    end
  endtask

  task automatic finish_txn(input string name);
    bus.iOut_ready = 1'b1;
    step();
    bus.iOut_ready = 1'b0;
    checks++;
    if (bus.oIn_ready !== 1'b1 || bus.oData_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release in_ready/data_valid got %b%b want 10", name,
               bus.oIn_ready, bus.oData_valid);
    end
  endtask

  task automatic test_reset();
    bus.iClear = 0; bus.iEndec = 0; bus.iRound = '0; bus.iData_valid = 0;
    bus.iData = '0; bus.iOut_ready = 0;
    iRst_n = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    checks++;
    if (bus.oIn_ready !== 1'b1 || bus.oBusy !== 1'b0 || bus.oCore_valid !== 1'b0 ||
        bus.oData_valid !== 1'b0 || bus.oLast_pass !== 1'b0 || bus.oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy%b busy%b cv%b dv%b lp%b ov%b want 100000",
               bus.oIn_ready, bus.oBusy, bus.oCore_valid, bus.oData_valid,
               bus.oLast_pass, bus.oOverrun);
    end
    checks++;
    if (bus.oKey_addr !== '0 || bus.oRound_idx !== '0 || bus.oData !== '0) begin
      errors++;
      $display("FAIL reset_values got key %0h idx %0h data %0h want 0 0 0",
               bus.oKey_addr, bus.oRound_idx, bus.oData);
    end
    iRst_n = 1'b1;
    step();
  endtask

  task automatic test_encrypt();
    int cyc, base;
    run_txn(1'b0, 4'd10, 128'h00112233_44556677_8899AABB_CCDDEEFF, 3, cyc, base);
    checks++;
    if (cyc !== 41) begin
      errors++; $display("FAIL enc_latency got %0d want 41", cyc);
    end
    checks++;
    if (bus.oData !== 128'h00112232_44556676_8899AABA_CCDDEEFE) begin
      errors++; $display("FAIL enc_data got %h want 00112232445566768899aabaccddeefe", bus.oData);
    end
    checks++;
    if (launchCount - base !== 10) begin
      errors++; $display("FAIL enc_launches got %0d want 10", launchCount - base);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (logAddr[base+i] !== ADDR_W'(i) || logLast[base+i] !== (i == 9)) begin
        errors++;
        $display("FAIL enc_pass%0d key/last got %0d/%b want %0d/%b", i, logAddr[base+i],
                 logLast[base+i], i, (i == 9));
      end
    end
    finish_txn("enc");
  endtask

  task automatic test_decrypt();
    int cyc, base;
    run_txn(1'b1, 4'd14, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1, cyc, base);
    checks++;
    if (cyc !== 29) begin
      errors++; $display("FAIL dec_latency got %0d want 29", cyc);
    end
    checks++;
    if (bus.oData !== 128'h0F0E0D0D_0B0A0909_07060505_03020101) begin
      errors++; $display("FAIL dec_data got %h want 0f0e0d0d0b0a09090706050503020101", bus.oData);
    end
    checks++;
    if (launchCount - base !== 14) begin
      errors++; $display("FAIL dec_launches got %0d want 14", launchCount - base);
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (logAddr[base+i] !== ADDR_W'(13 - i) || logLast[base+i] !== (i == 13)) begin
        errors++;
        $display("FAIL dec_pass%0d key/last got %0d/%b want %0d/%b", i, logAddr[base+i],
                 logLast[base+i], 13 - i, (i == 13));
      end
    end
    checks++;
    if (logIdx[base+13] !== 4'd13) begin
      errors++; $display("FAIL dec_last_idx got %0d want 13", logIdx[base+13]);
    end
    finish_txn("dec");
  endtask

  task automatic test_passthrough();
    int cyc, base;
    run_txn(1'b0, 4'd0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1, cyc, base);
    checks++;
    if (cyc !== 1) begin
      errors++; $display("FAIL n0_latency got %0d want 1", cyc);
    end
    checks++;
    if (bus.oData !== 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF) begin
      errors++; $display("FAIL n0_data got %h want deadbeef x4", bus.oData);
    end
    checks++;
    if (launchCount - base !== 0) begin
      errors++; $display("FAIL n0_launches got %0d want 0", launchCount - base);
    end
    finish_txn("n0");
  endtask

  task automatic test_backpressure();
    int cyc, base;
    run_txn(1'b0, 4'd0, {4{32'h11111111}}, 1, cyc, base);
    for (int i = 0; i < 5; i++) begin
      bus.iData_valid = (i % 2 == 0);
      bus.iData = {4{32'h55555555}};
      bus.iRound = 4'd0;
      step();
      checks++;
      if (bus.oData !== {4{32'h11111111}} || bus.oIn_ready !== 1'b0 ||
          bus.oData_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d data %h rdy %b dv %b want 1111.. 0 1", i, bus.oData,
                 bus.oIn_ready, bus.oData_valid);
      end
    end
    bus.iData_valid = 1'b0;
    finish_txn("bp");
    run_txn(1'b0, 4'd0, {4{32'h22222222}}, 1, cyc, base);
    checks++;
    if (cyc !== 1 || bus.oData !== {4{32'h22222222}}) begin
      errors++;
      $display("FAIL bp_next got cyc %0d data %h want 1 2222..", cyc, bus.oData);
    end
    finish_txn("bp_next");
  endtask

  task automatic test_clear();
    int w;
    coreLat = 3;
    coreEn  = 1'b1;
    bus.iData = {4{32'hA5A5A5A5}}; bus.iRound = 4'd8; bus.iEndec = 1'b0;
    bus.iData_valid = 1'b1;
    step();
    bus.iData_valid = 1'b0;
    w = 0;
    while (!(bus.oCore_valid && bus.oRound_idx == 4'd4) && w < 200) begin
      step();
      w++;
    end
    coreEn = 1'b0;
    step();
    checks++;
    if (bus.oBusy !== 1'b1 || bus.oCore_valid !== 1'b0 || bus.oRound_idx !== 4'd4) begin
      errors++;
      $display("FAIL clr_wait busy %b cv %b idx %0d want 1 0 4", bus.oBusy, bus.oCore_valid,
               bus.oRound_idx);
    end
    bus.iClear = 1'b1;
    step();
    bus.iClear = 1'b0;
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oIn_ready !== 1'b1 || bus.oRound_idx !== '0 ||
        bus.oKey_addr !== '0 || bus.oCore_data !== '0 || bus.oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle busy %b rdy %b idx %0d key %0d ov %b want 0 1 0 0 0",
               bus.oBusy, bus.oIn_ready, bus.oRound_idx, bus.oKey_addr, bus.oOverrun);
    end
    step();
    manualValid = 1'b1;
    manualData  = {4{32'hFFFF0000}};
    step();
    manualValid = 1'b0;
    checks++;
    if (bus.oOverrun !== 1'b1 || bus.oBusy !== 1'b0 || bus.oCore_data !== '0) begin
      errors++;
      $display("FAIL clr_late_core ov %b busy %b data %h want 1 0 0", bus.oOverrun, bus.oBusy,
               bus.oCore_data);
    end
    bus.iClear = 1'b1;
    step();
    bus.iClear = 1'b0;
    checks++;
    if (bus.oOverrun !== 1'b0) begin
      errors++; $display("FAIL clr_overrun got %b want 0", bus.oOverrun);
    end
    coreEn = 1'b1;
  endtask

  task automatic test_reset_mid_issue();
    int w, cyc, base;
    coreLat = 2;
    coreEn  = 1'b1;
    bus.iData = {4{32'h0BADF00D}}; bus.iRound = 4'd3; bus.iEndec = 1'b1;
    bus.iData_valid = 1'b1;
    step();
    bus.iData_valid = 1'b0;
    w = 0;
    while (!bus.oCore_valid && w < 20) begin
      step();
      w++;
    end
    #3;
    iRst_n = 1'b0;
    #1;
    checks++;
    if (bus.oCore_valid !== 1'b0 || bus.oBusy !== 1'b0 || bus.oIn_ready !== 1'b1 ||
        bus.oKey_addr !== '0 || bus.oLast_pass !== 1'b0 || bus.oCore_data !== '0 ||
        bus.oRound_idx !== '0 || bus.oData_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async cv %b busy %b rdy %b key %0d lp %b data %h want 0 0 1 0 0 0",
               bus.oCore_valid, bus.oBusy, bus.oIn_ready, bus.oKey_addr, bus.oLast_pass,
               bus.oCore_data);
    end
    step();
    iRst_n = 1'b1;
    step();
    step();
    checks++;
    if (bus.oOverrun !== 1'b1) begin
      errors++; $display("FAIL rst_late_overrun got %b want 1", bus.oOverrun);
    end
    run_txn(1'b0, 4'd1, {4{32'h12345678}}, 2, cyc, base);
    checks++;
    if (cyc !== 4 || bus.oData !== {4{32'h12345678}}) begin
      errors++;
      $display("FAIL rst_fresh got cyc %0d data %h want 4 12345678 x4", cyc, bus.oData);
    end
    finish_txn("rst_fresh");
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_passthrough();
    test_backpressure();
    test_clear();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/round_iteration_sequencer.md
Name: round_iteration_sequencer

Overview:
- Parametrised successor to the fixed 4x32-bit iterative round controller in the cipher datapath.
- Accepts one block per transaction and drives an external single-round core for N passes, feeding each result back in as the next input.
- Generates the per-pass key-RAM address, ascending for encrypt and descending for decrypt, and flags the final pass.
- Adds input/output ready-valid backpressure, N=0 pass-through, synchronous abort and sticky error status.

Parameters:
WORD_W, 32, width of one data word
NUM_WORDS, 4, words per block; block bus width B = NUM_WORDS*WORD_W
ROUND_W, 4, width of the round-count field; N ranges 0..2^ROUND_W-1
ADDR_W, 4, key-RAM address width; must be >= ROUND_W

Ports:
iClk  in  1  clock, all logic on rising edge
iRst_n  in  1  asynchronous active-low reset
iClear  in  1  synchronous abort to IDLE, also clears oOverrun
iEndec  in  1  0 = encrypt, 1 = decrypt; sampled on input accept
iRound  in  ROUND_W  pass count N; sampled on input accept
iData_valid  in  1  input block valid
oIn_ready  out  1  block accepts input; high only in IDLE
iData  in  B  input block
oCore_valid  out  1  one-cycle launch pulse to the round core
oCore_data  out  B  round-core input block (state register)
oKey_addr  out  ADDR_W  key-RAM address for the current pass
oLast_pass  out  1  high with oCore_valid on the final pass
iCore_valid  in  1  round-core result valid
iCore_data  in  B  round-core result
oData_valid  out  1  result valid
oData  out  B  result block
iOut_ready  in  1  downstream accepts result
oBusy  out  1  high whenever state != IDLE
oRound_idx  out  ROUND_W  current pass index r
oOverrun  out  1  sticky: iCore_valid seen outside WAIT

Behaviour:
- Async reset, and iClear on a clock edge (iClear has priority over all other events):
  - state=IDLE; r=0; state register=0.
  - oCore_valid=0, oData_valid=0, oKey_addr=0, oLast_pass=0, oBusy=0.
  - oIn_ready=1 after reset or clear.
  - oOverrun=0 (reset and iClear both clear it).
- FSM states IDLE, ISSUE, WAIT, DONE:
  - IDLE:
    - On iData_valid & oIn_ready: capture iData into the state register, latch N and Endec, set r=0.
    - Go to ISSUE if N!=0; go to DONE if N=0 (pass-through, data unchanged).
  - ISSUE (exactly one cycle):
    - oCore_valid=1; oCore_data=state register.
    - oLast_pass=(r==N-1).
    - Go to WAIT.
  - WAIT:
    - On iCore_valid: state register <= iCore_data.
    - If r==N-1, go to DONE; else r<=r+1 and go to ISSUE.
  - DONE:
    - oData_valid=1; oData=state register, held stable.
    - On iOut_ready go to IDLE; oIn_ready rises the next cycle.
    - No bypass of the DONE-to-IDLE cycle.
- Key address is registered and valid during ISSUE, held through WAIT:
  - Encrypt: oKey_addr = r.
  - Decrypt: oKey_addr = N-1-r.
  - Computed zero-extended to ADDR_W.
- Latency, with core latency L>=1 cycles from oCore_valid to iCore_valid and accept in cycle 0:
  - Pass k issues in cycle 1+k*(L+1).
  - oData_valid first high in cycle N*(L+1)+1.
  - N=0 gives oData_valid in cycle 1.
- Boundary cases:
  - iData_valid while not IDLE: ignored, no capture.
  - iCore_valid in IDLE, ISSUE or DONE: data ignored, oOverrun<=1.
  - A core response arriving in the same cycle as oCore_valid is impossible (L>=1).
  - N=2^ROUND_W-1: r counts to its maximum with no wrap.
  - iRound and iEndec changing mid-transaction have no effect.
  - Reset asserted mid-pass: immediate return to reset values; the late core result counts as out-of-WAIT and sets oOverrun.
- All outputs are registered or decoded from state only; there is no combinational path from iCore_* or iOut_ready to outputs.

Test Plan:
- Encrypt, N=10, core model L=3 returning data XOR key_addr, iData=0x00112233_44556677_8899AABB_CCDDEEFF:
  - oKey_addr = 0..9 on successive oCore_valid.
  - oLast_pass only on the 10th launch.
  - oData_valid in cycle 41; oData = iData XOR 0x1 (XOR of addresses 0..9 = 1, applied per word).
- Decrypt, N=14, L=1:
  - oKey_addr sequence 13,12,...,0.
  - oData_valid in cycle 29.
  - oRound_idx=13 on the last launch.
- N=0, iData=0xDEADBEEF repeated:
  - oData_valid in cycle 1 with oData=iData.
  - oCore_valid never asserted.
- Backpressure: hold iOut_ready=0 for 5 cycles after oData_valid, and pulse iData_valid during those cycles:
  - oData stable; oIn_ready=0; the pulsed input is not captured.
  - iOut_ready=1 gives IDLE next cycle, then a new accept.
- iClear during WAIT of pass 4, core then returns 2 cycles later:
  - IDLE and oBusy=0 one cycle after iClear.
  - Late iCore_valid sets oOverrun=1; a second iClear returns it to 0.
- Async reset asserted mid-ISSUE (no clock edge needed):
  - All outputs return to reset values immediately.
  - After release, a fresh N=1 transaction with L=2 completes in cycle 4.
